// File: rtl/graycode_pkg.sv
// Shared Gray-code helpers, wrap-mode constants and the per-edge action type
// used by the Gray up/down counter.
package graycode_pkg;

    localparam int MAX_WIDTH = 16;

    localparam bit MODE_WRAP = 1'b1;
    localparam bit MODE_SAT  = 1'b0;

    typedef enum logic [2:0] {
        ACT_HOLD,
        ACT_CLR,
        ACT_LOAD,
        ACT_UP,
        ACT_DOWN
    } action_t;

    function automatic logic [MAX_WIDTH-1:0] bin2gray(input logic [MAX_WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Each binary bit is the XOR of all Gray bits at and above it.
    function automatic logic [MAX_WIDTH-1:0] gray2bin(input logic [MAX_WIDTH-1:0] g);
        logic [MAX_WIDTH-1:0] b;
        b[MAX_WIDTH-1] = g[MAX_WIDTH-1];
        for (int i = MAX_WIDTH-2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray2bin.sv
// Purely combinational Gray-to-binary converter, used on the counter load path.
module gray2bin #(
    parameter int WIDTH = 4
)(
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    assign bin = WIDTH'(graycode_pkg::gray2bin(graycode_pkg::MAX_WIDTH'(gray)));

endmodule

// File: rtl/gray_updown_counter.sv
// Up/down counter keeping a binary and a Gray register in lock-step; CODE comes
// straight from the Gray flop. Wraps or saturates at the ends depending on WRAP.
module gray_updown_counter
    import graycode_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter bit WRAP  = MODE_WRAP
)(
    input  logic             CLK,
    input  logic             RST,
    input  logic             CLR,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] LOAD_CODE,
    input  logic             UP,
    input  logic             DOWN,
    output logic [WIDTH-1:0] CODE,
    output logic [WIDTH-1:0] BIN,
    output logic             AT_MAX,
    output logic             AT_MIN,
    output logic             WRAPPED
);

    localparam logic [WIDTH-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] bin_q;
    logic [WIDTH-1:0] code_q;
    logic             wrapped_q;
    logic [WIDTH-1:0] bin_d;
    logic [WIDTH-1:0] code_d;
    logic             wrapped_d;
    logic [WIDTH-1:0] load_bin;
    logic             at_max;
    logic             at_min;
    action_t          action;

    gray2bin #(.WIDTH(WIDTH)) u_load_conv (
        .gray (LOAD_CODE),
        .bin  (load_bin)
    );

    assign at_max = (bin_q == CNT_MAX);
    assign at_min = (bin_q == '0);

    always_comb begin
        action = ACT_HOLD;
        if (CLR) begin
            action = ACT_CLR;
        end else if (LOAD) begin
            action = ACT_LOAD;
        end else if (UP && !DOWN) begin
            action = ACT_UP;
        end else if (DOWN && !UP) begin
            action = ACT_DOWN;
        end
    end

    // End-of-range steps either wrap (flagging it) or are swallowed in saturate mode.
    always_comb begin
        bin_d     = bin_q;
        code_d    = code_q;
        wrapped_d = 1'b0;
        case (action)
            ACT_CLR: begin
                bin_d  = '0;
                code_d = '0;
            end
            ACT_LOAD: begin
                bin_d  = load_bin;
                code_d = LOAD_CODE;
            end
            ACT_UP: begin
                if (!at_max) begin
                    bin_d  = bin_q + WIDTH'(1);
                    code_d = WIDTH'(bin2gray(MAX_WIDTH'(bin_d)));
                end else if (WRAP == MODE_WRAP) begin
                    bin_d     = '0;
                    code_d    = '0;
                    wrapped_d = 1'b1;
                end
            end
            ACT_DOWN: begin
                if (!at_min) begin
                    bin_d  = bin_q - WIDTH'(1);
                    code_d = WIDTH'(bin2gray(MAX_WIDTH'(bin_d)));
                end else if (WRAP == MODE_WRAP) begin
                    bin_d     = CNT_MAX;
                    code_d    = WIDTH'(bin2gray(MAX_WIDTH'(CNT_MAX)));
                    wrapped_d = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            bin_q     <= '0;
            code_q    <= '0;
            wrapped_q <= 1'b0;
        end else begin
            bin_q     <= bin_d;
            code_q    <= code_d;
            wrapped_q <= wrapped_d;
        end
    end

    assign CODE    = code_q;
    assign BIN     = bin_q;
    assign AT_MAX  = at_max;
    assign AT_MIN  = at_min;
    assign WRAPPED = wrapped_q;

endmodule

// File: tb/tb_gray_updown_counter.sv
// Directed bench for gray_updown_counter: one wrapping and one saturating
// instance share stimulus and are checked every cycle against an integer model.
module tb_gray_updown_counter;

    localparam int W    = 4;
    localparam int MAXV = 15;

    logic         CLK       = 1'b0;
    logic         RST       = 1'b1;
    logic         CLR       = 1'b0;
    logic         LOAD      = 1'b0;
    logic [W-1:0] LOAD_CODE = '0;
    logic         UP        = 1'b0;
    logic         DOWN      = 1'b0;

    logic [W-1:0] codeW, binW, codeS, binS;
    logic         atMaxW, atMinW, wrappedW;
    logic         atMaxS, atMinS, wrappedS;

    int vectors     = 0;
    int miscompares = 0;

    int           cntW        = 0;
    int           cntS        = 0;
    bit           wrapW       = 1'b0;
    bit           movedW      = 1'b0;
    bit           checkEn     = 1'b0;
    logic [W-1:0] codeBeforeW = '0;

    gray_updown_counter #(.WIDTH(W), .WRAP(1'b1)) dutWrap (
        .CLK(CLK), .RST(RST), .CLR(CLR), .LOAD(LOAD), .LOAD_CODE(LOAD_CODE),
        .UP(UP), .DOWN(DOWN), .CODE(codeW), .BIN(binW),
        .AT_MAX(atMaxW), .AT_MIN(atMinW), .WRAPPED(wrappedW)
    );

    gray_updown_counter #(.WIDTH(W), .WRAP(1'b0)) dutSat (
        .CLK(CLK), .RST(RST), .CLR(CLR), .LOAD(LOAD), .LOAD_CODE(LOAD_CODE),
        .UP(UP), .DOWN(DOWN), .CODE(codeS), .BIN(binS),
        .AT_MAX(atMaxS), .AT_MIN(atMinS), .WRAPPED(wrappedS)
    );

    always #5 CLK = ~CLK;

    function automatic int grayOf(input int n);
        return n ^ (n >> 1);
    endfunction

    // Inverse by search over the code space rather than a bit-serial conversion.
    function automatic int grayToInt(input logic [W-1:0] g);
        for (int b = 0; b <= MAXV; b++) begin
            if (grayOf(b) == int'(g)) return b;
        end
        return 0;
    endfunction

    task automatic checkOutput(input string name, input logic [15:0] actual,
                               input logic [15:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic clr, input logic load, input logic [W-1:0] lc,
                                 input logic up, input logic down);
        @(negedge CLK);
        CLR       = clr;
        LOAD      = load;
        LOAD_CODE = lc;
        UP        = up;
        DOWN      = down;
        @(posedge CLK);
        #3;
    endtask

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            cntW   = 0;
            cntS   = 0;
            wrapW  = 1'b0;
            movedW = 1'b0;
        end else begin
            codeBeforeW = codeW;
            wrapW       = 1'b0;
            movedW      = 1'b0;
            if (CLR) begin
                cntW = 0;
                cntS = 0;
            end else if (LOAD) begin
                cntW = grayToInt(LOAD_CODE);
                cntS = grayToInt(LOAD_CODE);
            end else if (UP && !DOWN) begin
                movedW = 1'b1;
                if (cntW == MAXV) begin
                    cntW  = 0;
                    wrapW = 1'b1;
                end else begin
                    cntW = cntW + 1;
                end
                if (cntS != MAXV) cntS = cntS + 1;
            end else if (DOWN && !UP) begin
                movedW = 1'b1;
                if (cntW == 0) begin
                    cntW  = MAXV;
                    wrapW = 1'b1;
                end else begin
                    cntW = cntW - 1;
                end
                if (cntS != 0) cntS = cntS - 1;
            end
        end
    end

    always @(posedge CLK) begin
        #2;
        if (checkEn) begin
            checkOutput("codeW",    16'(codeW),    16'(grayOf(cntW)));
            checkOutput("binW",     16'(binW),     16'(cntW));
            checkOutput("atMaxW",   16'(atMaxW),   16'(cntW == MAXV));
            checkOutput("atMinW",   16'(atMinW),   16'(cntW == 0));
            checkOutput("wrappedW", 16'(wrappedW), 16'(wrapW));
            checkOutput("codeS",    16'(codeS),    16'(grayOf(cntS)));
            checkOutput("binS",     16'(binS),     16'(cntS));
            checkOutput("atMaxS",   16'(atMaxS),   16'(cntS == MAXV));
            checkOutput("atMinS",   16'(atMinS),   16'(cntS == 0));
            checkOutput("wrappedS", 16'(wrappedS), 16'd0);
            if (movedW) begin
                vectors++;
                assert ($countones(codeW ^ codeBeforeW) == 1)
                else begin
                    miscompares++;
                    $display("[TB] FAIL onebit: code %b -> %b at %0t", codeBeforeW, codeW, $time);
                end
            end
        end
    end

    initial begin
        logic [W-1:0] upSeq [17];
        upSeq = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
                  4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000,
                  4'b0000};

        repeat (2) @(negedge CLK);
        checkEn = 1'b1;
        #1;
        checkOutput("rst_code",    16'(codeW),    16'd0);
        checkOutput("rst_bin",     16'(binW),     16'd0);
        checkOutput("rst_atmin",   16'(atMinW),   16'd1);
        checkOutput("rst_atmax",   16'(atMaxW),   16'd0);
        checkOutput("rst_wrapped", 16'(wrappedW), 16'd0);
        @(negedge CLK);
        RST = 1'b0;

        for (int i = 1; i <= 16; i++) begin
            applyStimulus(1'b0, 1'b0, 4'b0000, 1'b1, 1'b0);
            checkOutput("up_seq_code", 16'(codeW),    16'(upSeq[i]));
            checkOutput("up_seq_wrap", 16'(wrappedW), 16'(i == 16));
        end
        applyStimulus(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0);
        checkOutput("up_wrap_drop", 16'(wrappedW), 16'd0);

        @(negedge CLK);
        RST = 1'b1;
        #2;
        checkOutput("pulse_rst_code", 16'(codeW), 16'd0);
        RST = 1'b0;
        applyStimulus(1'b0, 1'b0, 4'b0000, 1'b0, 1'b1);
        checkOutput("down_wrap_code",  16'(codeW),    16'b1000);
        checkOutput("down_wrap_bin",   16'(binW),     16'b1111);
        checkOutput("down_wrap_atmax", 16'(atMaxW),   16'd1);
        checkOutput("down_wrap_flag",  16'(wrappedW), 16'd1);
        checkOutput("down_sat_code",   16'(codeS),    16'b0000);
        checkOutput("down_sat_flag",   16'(wrappedS), 16'd0);
        applyStimulus(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0);
        checkOutput("down_wrap_drop",  16'(wrappedW), 16'd0);

        applyStimulus(1'b0, 1'b1, 4'b0110, 1'b1, 1'b0);
        checkOutput("load_code", 16'(codeW), 16'b0110);
        checkOutput("load_bin",  16'(binW),  16'b0100);
        applyStimulus(1'b1, 1'b1, 4'b0110, 1'b0, 1'b0);
        checkOutput("clr_over_load_code",  16'(codeW),  16'b0000);
        checkOutput("clr_over_load_atmin", 16'(atMinW), 16'd1);

        applyStimulus(1'b0, 1'b1, 4'b0111, 1'b0, 1'b0);
        checkOutput("load_0101_bin", 16'(binW), 16'b0101);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 4'b0000, 1'b1, 1'b1);
            checkOutput("updown_hold_code", 16'(codeW),    16'b0111);
            checkOutput("updown_hold_wrap", 16'(wrappedW), 16'd0);
        end
        applyStimulus(1'b0, 1'b0, 4'b0000, 1'b0, 1'b1);
        checkOutput("down_step_code", 16'(codeW), 16'b0110);
        checkOutput("down_step_bin",  16'(binW),  16'b0100);

        applyStimulus(1'b0, 1'b1, 4'b1101, 1'b1, 1'b0);
        checkOutput("load_1001_bin", 16'(binW), 16'b1001);
        @(negedge CLK);
        LOAD = 1'b0;
        UP   = 1'b1;
        RST  = 1'b1;
        #1;
        checkOutput("mid_rst_code", 16'(codeW), 16'd0);
        checkOutput("mid_rst_bin",  16'(binW),  16'd0);
        #1;
        RST = 1'b0;
        @(posedge CLK);
        #3;
        checkOutput("post_rst_code", 16'(codeW), 16'b0001);

        applyStimulus(1'b0, 1'b1, 4'b1000, 1'b0, 1'b0);
        checkOutput("load_max_binS",   16'(binS),   16'b1111);
        checkOutput("load_max_atmaxS", 16'(atMaxS), 16'd1);
        applyStimulus(1'b0, 1'b0, 4'b0000, 1'b1, 1'b0);
        checkOutput("sat_up_codeS",  16'(codeS),    16'b1000);
        checkOutput("sat_up_flagS",  16'(wrappedS), 16'd0);
        checkOutput("wrap_up_codeW", 16'(codeW),    16'b0000);
        checkOutput("wrap_up_flagW", 16'(wrappedW), 16'd1);
        applyStimulus(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/gray_updown_counter.md
GRAY_UPDOWN_COUNTER -- requirements
Module: gray_updown_counter

Interface
REQ-001 Parameter WIDTH, default 4, counter width in bits; legal range 2..16.
REQ-002 Parameter WRAP, default 1; 1 = modulo wrap-around, 0 = saturate at the end values.
REQ-003 CLK  input  1  single clock; all state changes on its rising edge.
REQ-004 RST  input  1  reset, asynchronous, active-high.
REQ-005 CLR  input  1  synchronous clear to zero.
REQ-006 LOAD  input  1  synchronous load of LOAD_CODE.
REQ-007 LOAD_CODE  input  WIDTH  load value, Gray-coded.
REQ-008 UP  input  1  count-up request.
REQ-009 DOWN  input  1  count-down request.
REQ-010 CODE  output  WIDTH  current count, Gray-coded.
REQ-011 BIN  output  WIDTH  current count, binary.
REQ-012 AT_MAX  output  1  high while count = 2^WIDTH-1.
REQ-013 AT_MIN  output  1  high while count = 0.
REQ-014 WRAPPED  output  1  single-cycle pulse after a wrap-around step.

Function
REQ-015 Per-edge priority SHALL be CLR > LOAD > count step > hold.
REQ-016 Count step SHALL be: UP=1 and DOWN=0 -> +1; DOWN=1 and UP=0 -> -1; UP=DOWN -> hold.
REQ-017 LOAD SHALL set BIN to the Gray-to-binary conversion of LOAD_CODE and CODE to LOAD_CODE; UP/DOWN in that cycle SHALL be ignored.
REQ-018 Latency SHALL be one cycle: outputs reflect an edge's action immediately after that edge.
REQ-019 CODE SHALL be driven directly from a flop, with no logic between register and port.
REQ-020 CODE SHALL always equal BIN ^ (BIN >> 1).
REQ-021 Each count step SHALL change exactly one bit of CODE; CLR, LOAD and RST are exempt.
REQ-022 WRAP=1: +1 at 2^WIDTH-1 SHALL give 0, and -1 at 0 SHALL give 2^WIDTH-1; both SHALL raise WRAPPED for exactly the following cycle.
REQ-023 WRAP=0: +1 at max and -1 at 0 SHALL hold the value, and WRAPPED SHALL stay 0.
REQ-024 WRAPPED SHALL be 0 after CLR, LOAD, hold and every non-wrapping step.
REQ-025 AT_MAX/AT_MIN SHALL be decoded from the registered count and be valid in the same cycle as CODE.

Reset
REQ-026 While RST=1, outputs SHALL be CODE=0, BIN=0, AT_MIN=1, AT_MAX=0, WRAPPED=0, regardless of CLK.
REQ-027 Reset asserted mid-count SHALL clear state immediately; the first edge after release SHALL act on the inputs normally.
REQ-028 All flops in the block SHALL be asynchronously reset.

Structure
REQ-029 Package graycode_pkg SHALL hold bin2gray/gray2bin functions and the WRAP mode constants (MODE_WRAP=1, MODE_SAT=0).
REQ-030 Sub-module gray2bin, parametrised by WIDTH and purely combinational, SHALL convert LOAD_CODE on the load path.
REQ-031 State SHALL be a binary register plus a Gray register updated in the same cycle; no other counters.

Verification (WIDTH=4)
REQ-032 Pulse RST high, then hold UP=1 for 16 cycles:
- CODE SHALL step 0000,0001,0011,0010,0110,0111,0101,0100,1100,1101,1111,1110,1010,1011,1001,1000,0000.
- WRAPPED SHALL pulse once, on the return to 0000.
- An assertion SHALL check the one-bit-change rule on every step.
REQ-033 From reset, DOWN=1 for one cycle -> CODE=1000, BIN=1111, AT_MAX=1, WRAPPED=1 for one cycle; repeat with WRAP=0 -> CODE stays 0000, WRAPPED=0.
REQ-034 LOAD=1, LOAD_CODE=0110, UP=1 -> CODE=0110, BIN=0100; the next cycle has CLR=1 and LOAD=1 together -> CODE=0000, AT_MIN=1.
REQ-035 At BIN=0101, UP=DOWN=1 for 3 cycles -> CODE holds 0111 and WRAPPED=0.
REQ-036 At BIN=1001 with UP held, assert RST between clock edges:
- CODE=0000 SHALL appear before the next edge.
- After RST release, the first edge with UP=1 SHALL give CODE=0001.
